// File: rtl/trace_pkg.sv
// Shared retire-class definitions and MIPS opcode/funct constants
// for the retirement trace buffer.
package trace_pkg;

  typedef enum logic [4:0] {
    CL_NOP   = 5'd0,
    CL_ADD   = 5'd1,
    CL_SUB   = 5'd2,
    CL_AND   = 5'd3,
    CL_OR    = 5'd4,
    CL_SLT   = 5'd5,
    CL_SRL   = 5'd6,
    CL_MFHI  = 5'd7,
    CL_MFLO  = 5'd8,
    CL_MULTU = 5'd9,
    CL_MADDU = 5'd10,
    CL_ADDIU = 5'd11,
    CL_LW    = 5'd12,
    CL_SW    = 5'd13,
    CL_BEQ   = 5'd14,
    CL_J     = 5'd15,
    CL_UNK   = 5'd16
  } trace_class_e;

  localparam int CLASS_N = 17;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_MADDU = 6'd28;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_NOP   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

endpackage

// File: rtl/trace_decode.sv
// Combinational instruction word to retire-class decoder.
// Shared between the trace buffer and its scoreboard.
module trace_decode
  import trace_pkg::*;
(
  input  logic [31:0]  i_instr,
  output trace_class_e o_class
);

  logic [5:0]   w_op;
  logic [5:0]   w_fn;
  trace_class_e w_rcls;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];

  always_comb begin
    w_rcls = CL_UNK;
    unique case (1'b1)
      (w_fn == FN_NOP):   w_rcls = CL_NOP;
      (w_fn == FN_ADD):   w_rcls = CL_ADD;
      (w_fn == FN_SUB):   w_rcls = CL_SUB;
      (w_fn == FN_AND):   w_rcls = CL_AND;
      (w_fn == FN_OR):    w_rcls = CL_OR;
      (w_fn == FN_SLT):   w_rcls = CL_SLT;
      (w_fn == FN_SRL):   w_rcls = CL_SRL;
      (w_fn == FN_MFHI):  w_rcls = CL_MFHI;
      (w_fn == FN_MFLO):  w_rcls = CL_MFLO;
      (w_fn == FN_MULTU): w_rcls = CL_MULTU;
      default:            w_rcls = CL_UNK;
    endcase
  end

  always_comb begin
    o_class = CL_UNK;
    unique case (1'b1)
      (w_op == OP_RTYPE): o_class = w_rcls;
      (w_op == OP_MADDU): o_class = CL_MADDU;
      (w_op == OP_ADDIU): o_class = CL_ADDIU;
      (w_op == OP_LW):    o_class = CL_LW;
      (w_op == OP_SW):    o_class = CL_SW;
      (w_op == OP_BEQ):   o_class = CL_BEQ;
      (w_op == OP_J):     o_class = CL_J;
      default:            o_class = CL_UNK;
    endcase
  end

endmodule

// File: rtl/retire_trace_buf.sv
// Write-back retirement trace FIFO with sequence stamps and sticky overflow.
// Per-class retire counters are built when RETIRE_TRACE_CNT_EN is defined.
module retire_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 32,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   freeze,
  input  logic                   ret_valid,
  input  logic [PC_W-1:0]        ret_pc,
  input  logic [31:0]            ret_instr,
  input  logic [DATA_W-1:0]      ret_wd,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [PC_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]      rd_wd,
  output logic [4:0]             rd_class,
  output logic [15:0]            rd_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic [4:0]             ctr_sel,
  output logic [CNT_W-1:0]       ctr_val
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0]   r_pc_m  [DEPTH];
  logic [DATA_W-1:0] r_wd_m  [DEPTH];
  logic [4:0]        r_cls_m [DEPTH];
  logic [15:0]       r_seq_m [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [15:0]   r_seq;
  logic          r_ovf;

  trace_class_e w_cls;
  logic         w_cap;
  logic         w_full;
  logic         w_pop;
  logic         w_drop;
  logic         w_wr;
  logic         w_hadv;

  trace_decode u_dec (
    .i_instr (ret_instr),
    .o_class (w_cls)
  );

  assign w_cap  = ret_valid && !freeze && !clr;
  assign w_full = (r_count == L_FULL);
  assign w_pop  = rd_valid && rd_ready && !clr;
  assign w_drop = w_cap && w_full && !w_pop;
  // In overwrite mode a drop still writes; the oldest is evicted via head.
  assign w_wr   = w_cap && (!w_full || w_pop || OVERWRITE);
  assign w_hadv = w_pop || (w_drop && OVERWRITE);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc_m[r_tail]  <= ret_pc;
      r_wd_m[r_tail]  <= ret_wd;
      r_cls_m[r_tail] <= w_cls;
      r_seq_m[r_tail] <= r_seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)   r_tail <= r_tail + 1'b1;
      if (w_hadv) r_head <= r_head + 1'b1;
      if (w_cap)  r_seq  <= r_seq + 1'b1;
      if (w_drop) r_ovf  <= 1'b1;
      unique case ({w_wr, w_hadv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_valid = (r_count != '0);
  assign count    = r_count;
  assign overflow = r_ovf;
  assign rd_pc    = rd_valid ? r_pc_m[r_head]  : '0;
  assign rd_wd    = rd_valid ? r_wd_m[r_head]  : '0;
  assign rd_class = rd_valid ? r_cls_m[r_head] : '0;
  assign rd_seq   = rd_valid ? r_seq_m[r_head] : '0;

`ifdef RETIRE_TRACE_CNT_EN
  logic [CNT_W-1:0] r_ctr [CLASS_N];
  logic [CNT_W-1:0] r_ctr_val;
  logic [CNT_W-1:0] w_sel_val;

  always_comb begin
    w_sel_val = '0;
    for (int i = 0; i < CLASS_N; i++) begin
      if (ctr_sel == 5'(i)) w_sel_val = r_ctr[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CLASS_N; i++) r_ctr[i] <= '0;
      r_ctr_val <= '0;
    end else if (clr) begin
      for (int i = 0; i < CLASS_N; i++) r_ctr[i] <= '0;
      r_ctr_val <= '0;
    end else begin
      for (int i = 0; i < CLASS_N; i++) begin
        if (w_cap && (w_cls == 5'(i))) r_ctr[i] <= r_ctr[i] + 1'b1;
      end
      r_ctr_val <= w_sel_val;
    end
  end

  assign ctr_val = r_ctr_val;
`else
  logic w_unused_sel;
  assign w_unused_sel = ^ctr_sel;
  assign ctr_val      = '0;
`endif

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed bench: one 16-deep and two 4-deep buffers (overwrite / drop-new)
// share stimulus; the class decoder is checked against a hand-made table.
module tb_retire_trace_buf;

`ifdef RETIRE_TRACE_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  localparam logic [31:0] I_ADD   = 32'h0000_0020;
  localparam logic [31:0] I_LW    = 32'h8C00_0000;
  localparam logic [31:0] I_J     = 32'h0800_0000;
  localparam logic [31:0] I_SW    = 32'hAC00_0000;
  localparam logic [31:0] I_ADDIU = 32'h2400_0000;
  localparam logic [31:0] I_UNK   = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst, clr, freeze, rv, rr;
  logic [31:0] pc, ins, wd;
  logic [4:0]  sel;

  logic        v0, v1, v2, o0, o1, o2;
  logic [31:0] p0, p1, p2, w0, w1, w2, cv0, cv1, cv2;
  logic [4:0]  c0, c1, c2;
  logic [15:0] s0, s1, s2;
  logic [4:0]  n0;
  logic [2:0]  n1, n2;

  logic [31:0] dins;
  logic [4:0]  dcls;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  retire_trace_buf #(.DEPTH(16), .OVERWRITE(1'b1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .freeze(freeze),
    .ret_valid(rv), .ret_pc(pc), .ret_instr(ins), .ret_wd(wd),
    .rd_ready(rr), .rd_valid(v0), .rd_pc(p0), .rd_wd(w0),
    .rd_class(c0), .rd_seq(s0), .count(n0), .overflow(o0),
    .ctr_sel(sel), .ctr_val(cv0)
  );

  retire_trace_buf #(.DEPTH(4), .OVERWRITE(1'b1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .freeze(freeze),
    .ret_valid(rv), .ret_pc(pc), .ret_instr(ins), .ret_wd(wd),
    .rd_ready(rr), .rd_valid(v1), .rd_pc(p1), .rd_wd(w1),
    .rd_class(c1), .rd_seq(s1), .count(n1), .overflow(o1),
    .ctr_sel(sel), .ctr_val(cv1)
  );

  retire_trace_buf #(.DEPTH(4), .OVERWRITE(1'b0)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .freeze(freeze),
    .ret_valid(rv), .ret_pc(pc), .ret_instr(ins), .ret_wd(wd),
    .rd_ready(rr), .rd_valid(v2), .rd_pc(p2), .rd_wd(w2),
    .rd_class(c2), .rd_seq(s2), .count(n2), .overflow(o2),
    .ctr_sel(sel), .ctr_val(cv2)
  );

  trace_decode u_dec (.i_instr(dins), .o_class(dcls));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [31:0] a, input logic [31:0] i,
                     input logic [31:0] d);
    rv  = 1'b1;
    pc  = a;
    ins = i;
    wd  = d;
    tick();
    rv  = 1'b0;
  endtask

  logic [31:0] dec_in  [18] = '{
    32'h0000_0000, 32'h0000_0020, 32'h0000_0022, 32'h0000_0024,
    32'h0000_0025, 32'h0000_002A, 32'h0000_0002, 32'h0000_0010,
    32'h0000_0012, 32'h0000_0019, 32'h7000_0001, 32'h2400_0005,
    32'h8C00_0000, 32'hAC00_0000, 32'h1000_0000, 32'h0800_0000,
    32'h0000_003F, 32'hFC00_0000
  };
  logic [4:0]  dec_exp [18] = '{
    5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
    5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd16
  };

  initial begin
    rst = 1'b0; clr = 1'b0; freeze = 1'b0; rv = 1'b0; rr = 1'b0;
    pc = '0; ins = '0; wd = '0; sel = '0; dins = '0;

    for (int i = 0; i < 18; i++) begin
      dins = dec_in[i];
      #1;
      chk($sformatf("dec%0d", i), 32'(dcls), 32'(dec_exp[i]));
    end

    tick(); tick();
    chk("rst_valid", v0, 0);
    chk("rst_count", n0, 0);
    chk("rst_ovf", o0, 0);
    chk("rst_pc", p0, 0);
    chk("rst_seq", s0, 0);
    chk("rst_ctr", cv0, 0);
    chk("rst_cnt4", n1, 0);
    rst = 1'b1;
    tick();

    ret(32'h00, I_ADD, 32'h11);
    ret(32'h04, I_LW, 32'h22);
    ret(32'h08, I_J, 32'h0);
    chk("b3_count", n0, 3);
    chk("b3_valid", v0, 1);
    chk("b3_pc", p0, 32'h00);
    chk("b3_cls", c0, 1);
    chk("b3_seq", s0, 0);
    chk("b3_wd", w0, 32'h11);
    rr = 1'b1;
    tick();
    chk("pop1_seq", s0, 1);
    chk("pop1_cls", c0, 12);
    chk("pop1_pc", p0, 32'h04);
    tick();
    chk("pop2_seq", s0, 2);
    chk("pop2_cls", c0, 15);
    tick();
    chk("pop3_valid", v0, 0);
    chk("pop3_count", n0, 0);
    chk("pop3_pc", p0, 0);
    chk("pop3_cnt_u2", n2, 0);
    rr = 1'b0;

    clr = 1'b1; rv = 1'b1; pc = 32'h40; ins = I_ADD;
    tick();
    clr = 1'b0; rv = 1'b0;
    chk("clr_count", n0, 0);
    chk("clr_valid", v0, 0);
    chk("clr_ctr", cv0, 0);

    for (int i = 0; i < 6; i++) ret(32'h100 + 32'(4 * i), I_SW, 32'(i));
    chk("ow16_count", n0, 6);
    chk("ow16_ovf", o0, 0);
    chk("ow16_seq", s0, 0);
    chk("ow1_count", n1, 4);
    chk("ow1_ovf", o1, 1);
    chk("ow1_seq", s1, 2);
    chk("ow1_pc", p1, 32'h108);
    chk("ow0_count", n2, 4);
    chk("ow0_ovf", o2, 1);
    chk("ow0_seq", s2, 0);
    chk("ow0_pc", p2, 32'h100);
    rr = 1'b1;
    tick();
    chk("ow1_p1", s1, 3);
    chk("ow0_p1", s2, 1);
    tick(); tick();
    chk("ow1_last", s1, 5);
    chk("ow0_last", s2, 3);
    chk("ow1_lastwd", w1, 5);
    chk("ow0_lastwd", w2, 3);
    tick();
    chk("ow1_empty", v1, 0);
    chk("ow0_empty", v2, 0);
    chk("ow16_left", n0, 2);
    chk("ow16_head", s0, 4);
    rr = 1'b0;
    ret(32'h200, I_SW, 32'h0);
    chk("ow0_gap_seq", s2, 6);
    chk("ow0_gap_cnt", n2, 1);
    chk("ow1_gap_seq", s1, 6);
    chk("ow0_sticky", o2, 1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ovf", o1, 0);
    for (int i = 0; i < 4; i++) ret(32'h300 + 32'(4 * i), I_ADDIU, 32'(i));
    chk("full_cnt1", n1, 4);
    chk("full_ovf1", o1, 0);
    chk("full_cnt2", n2, 4);
    rr = 1'b1;
    ret(32'h310, I_ADDIU, 32'h4);
    rr = 1'b0;
    chk("cp_cnt1", n1, 4);
    chk("cp_ovf1", o1, 0);
    chk("cp_seq1", s1, 1);
    chk("cp_cnt2", n2, 4);
    chk("cp_ovf2", o2, 0);
    chk("cp_seq2", s2, 1);
    chk("cp_cnt0", n0, 4);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    rr = 1'b1;
    ret(32'h400, I_SW, 32'h0);
    rr = 1'b0;
    chk("ecp_count", n0, 1);
    chk("ecp_seq", s0, 0);
    chk("ecp_cls", c0, 13);
    ret(32'h404, I_SW, 32'h1);
    ret(32'h408, I_SW, 32'h2);
    ret(32'h40C, I_UNK, 32'h3);
    ret(32'h410, I_UNK, 32'h4);
    chk("ctr_count", n0, 5);
    sel = 5'd13;
    tick(); tick();
    chk("ctr_sw", cv0, CE ? 3 : 0);
    sel = 5'd16;
    tick(); tick();
    chk("ctr_unk", cv0, CE ? 2 : 0);
    sel = 5'd20;
    tick(); tick();
    chk("ctr_20", cv0, 0);
    sel = 5'd12;
    tick(); tick();
    chk("ctr_lw", cv0, 0);

    sel = 5'd13;
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) ret(32'h500 + 32'(4 * i), I_SW, 32'h9);
    freeze = 1'b0;
    tick(); tick();
    chk("frz_count", n0, 5);
    chk("frz_seq", s0, 0);
    chk("frz_ctr", cv0, CE ? 3 : 0);
    rr = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rr = 1'b0;
    chk("frz_drain", v0, 0);
    ret(32'h600, I_ADD, 32'h55);
    chk("frz_nseq", s0, 5);
    chk("frz_ncls", c0, 1);
    chk("frz_nwd", w0, 32'h55);

    ret(32'h604, I_LW, 32'h1);
    chk("pre_rst_cnt", n0, 2);
    rst = 1'b0;
    #2;
    chk("arst_valid", v0, 0);
    chk("arst_count", n0, 0);
    chk("arst_pc", p0, 0);
    chk("arst_cnt4", n1, 0);
    chk("arst_ctr", cv0, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_valid", v0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
